result_writer_bram: RTL

Downstream stage of the block-matrix multiply core. Collects the pairs of 16-bit products that the core emits on its valid strobe. Packs each pair into one 32-bit word and writes it to a BRAM port at consecutive addresses from a programmed base. Signals completion once a programmed number of BLOCK_SIZE×BLOCK_SIZE result blocks has been stored.

---
 rtl/result_writer_bram_pkg.sv | 23 ++
 rtl/result_writer_bram_if.sv | 39 +++
 rtl/result_writer_bram.sv | 130 +++++++++++++
 3 files changed

// File: rtl/result_writer_bram_pkg.sv
// Shared definitions for the result writer: FSM states, block geometry and
// the packed result-word width shared with the matrix core's data bus.
package result_writer_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned CORE_IN_DATA_WIDTH = 8;
  localparam int unsigned CORE_BUS_WIDTH     = 4 * CORE_IN_DATA_WIDTH;

  // Two result lanes are packed per BRAM word, so a block needs n*n/2 words.
  function automatic int unsigned words_per_block(input int unsigned block_size);
    return (block_size * block_size) / 2;
  endfunction

  function automatic int unsigned packed_width(input int unsigned in_data_width);
    return 4 * in_data_width;
  endfunction

endpackage

// File: rtl/result_writer_bram_if.sv
// Result-pair input, control and BRAM write-port signals of the result writer.
interface result_writer_bram_if
  import result_writer_bram_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH    = 12
);

  localparam int unsigned RES_W  = 2 * IN_DATA_WIDTH;
  localparam int unsigned WORD_W = packed_width(IN_DATA_WIDTH);

  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic [7:0]            i_num_blocks;
  logic                  i_valid;
  logic [RES_W-1:0]      i_result0;
  logic [RES_W-1:0]      i_result1;
  logic                  o_bram_en;
  logic                  o_bram_we;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic [WORD_W-1:0]     o_bram_wdata;
  logic                  o_busy;
  logic                  o_block_done;
  logic                  o_done;
  logic                  o_err;

  modport slave (
    input  i_start, i_base_addr, i_num_blocks, i_valid, i_result0, i_result1,
    output o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata,
           o_busy, o_block_done, o_done, o_err
  );

  modport master (
    output i_start, i_base_addr, i_num_blocks, i_valid, i_result0, i_result1,
    input  o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata,
           o_busy, o_block_done, o_done, o_err
  );

endinterface

// File: rtl/result_writer_bram.sv
// Packs result pairs from the matrix core into 32-bit words and writes them to
// consecutive BRAM addresses until the programmed number of blocks is stored.
module result_writer_bram
  import result_writer_bram_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned BLOCK_SIZE    = 16,
  parameter int unsigned ADDR_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  result_writer_bram_if.slave   bus
);

  localparam int unsigned WPB    = words_per_block(BLOCK_SIZE);
  localparam int unsigned WCW    = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned WORD_W = packed_width(IN_DATA_WIDTH);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WPB - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [7:0]            blk_cnt_q, blk_cnt_d;
  logic [7:0]            nblk_q, nblk_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  block_done_q, block_done_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      word_cnt_q   <= '0;
      blk_cnt_q    <= '0;
      nblk_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      nblk_q       <= nblk_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      block_done_q <= block_done_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    nblk_d       = nblk_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    block_done_d = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          addr_d     = bus.i_base_addr;
          nblk_d     = bus.i_num_blocks;
          word_cnt_d = '0;
          blk_cnt_d  = '0;
          err_d      = 1'b0;
          state_d    = (bus.i_num_blocks == 8'd0) ? ST_DONE : ST_RUN;
        end else if (bus.i_valid) begin
          err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.i_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {bus.i_result1, bus.i_result0};
          addr_d  = addr_q + ADDR_WIDTH'(1);
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d   = '0;
            blk_cnt_d    = blk_cnt_q + 8'd1;
            block_done_d = 1'b1;
            if (blk_cnt_q == nblk_q - 8'd1) begin
              state_d = ST_DONE;
            end
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (bus.i_valid) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy covers DONE as well so it drops in the same cycle o_done rises.
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.o_bram_en    = we_q;
  assign bus.o_bram_we    = we_q;
  assign bus.o_bram_addr  = waddr_q;
  assign bus.o_bram_wdata = wdata_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_block_done = block_done_q;
  assign bus.o_done       = done_q;
  assign bus.o_err        = err_q;

endmodule
